// File: rtl/sram_mem_bridge.sv
// Merges the fetch and data SRAM-like channels onto one shared memory port,
// one transaction outstanding, with fixed-priority or round-robin arbitration.
module sram_mem_bridge #(
  parameter bit          DATA_PRIO = 1'b1,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_req,
  input  logic [ADDR_W-1:0]     inst_addr,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [DATA_W/8-1:0]   data_wstrb,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  typedef struct packed {
    logic              owner_data;
    logic              wr;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;
  logic   last_data;
  logic   grant_inst, grant_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Arbitration and next state; last_data=0 means inst was granted last.
  always_comb begin
    state_nxt  = state;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    case (state)
      IDLE: begin
        if (data_req && (!inst_req || DATA_PRIO || !last_data)) grant_data = 1'b1;
        else if (inst_req)                                      grant_inst = 1'b1;
        if (grant_data || grant_inst) state_nxt = ISSUE;
      end
      ISSUE:   if (mem_gnt)    state_nxt = WAIT;
      WAIT:    if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by reset so nothing is acknowledged while the bridge is held in reset.
  assign inst_addr_ok = grant_inst & resetn;
  assign data_addr_ok = grant_data & resetn;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_q     <= '0;
      last_data <= 1'b0;
    end else if (grant_data) begin
      req_q.owner_data <= 1'b1;
      req_q.wr         <= data_wr;
      req_q.wstrb      <= data_wr ? data_wstrb : STRB_W'(0);
      req_q.addr       <= data_addr;
      req_q.wdata      <= data_wdata;
      last_data        <= 1'b1;
    end else if (grant_inst) begin
      req_q.owner_data <= 1'b0;
      req_q.wr         <= 1'b0;
      req_q.wstrb      <= STRB_W'(0);
      req_q.addr       <= inst_addr;
      req_q.wdata      <= DATA_W'(0);
      last_data        <= 1'b0;
    end
  end

  // Response capture; a response outside WAIT only raises the sticky error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
      err          <= 1'b0;
    end else begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      if (state == WAIT && mem_rvalid) begin
        if (req_q.owner_data) begin
          data_data_ok <= 1'b1;
          if (!req_q.wr) data_rdata <= mem_rdata;
        end else begin
          inst_data_ok <= 1'b1;
          inst_rdata   <= mem_rdata;
        end
      end
      if (mem_rvalid && state != WAIT) err <= 1'b1;
    end
  end

  assign mem_req   = (state == ISSUE);
  assign mem_wr    = req_q.wr;
  assign mem_wstrb = req_q.wstrb;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sram_mem_bridge.sv
// Directed bench for sram_mem_bridge: instance 0 uses data priority,
// instance 1 round-robin; both see identical stimulus.
module tb_sram_mem_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        inst_addr_ok [2];
  logic        inst_data_ok [2];
  logic [31:0] inst_rdata   [2];
  logic        data_addr_ok [2];
  logic        data_data_ok [2];
  logic [31:0] data_rdata   [2];
  logic        mem_req      [2];
  logic        mem_wr       [2];
  logic [3:0]  mem_wstrb    [2];
  logic [31:0] mem_addr     [2];
  logic [31:0] mem_wdata    [2];
  logic        busy         [2];
  logic        err          [2];

  int errors = 0;
  int checks = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_mem_bridge #(
      .DATA_PRIO (g == 0),
      .ADDR_W    (32),
      .DATA_W    (32)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok[g]),
      .inst_data_ok (inst_data_ok[g]),
      .inst_rdata   (inst_rdata[g]),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok[g]),
      .data_data_ok (data_data_ok[g]),
      .data_rdata   (data_rdata[g]),
      .mem_req      (mem_req[g]),
      .mem_wr       (mem_wr[g]),
      .mem_wstrb    (mem_wstrb[g]),
      .mem_addr     (mem_addr[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .busy         (busy[g]),
      .err          (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge; inputs for the new cycle go here.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0; inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2;
    chk("rst_busy",   32'(busy[0]), 32'd0);
    chk("rst_err",    32'(err[0]), 32'd0);
    chk("rst_memreq", 32'(mem_req[0]), 32'd0);
    chk("rst_irdata", inst_rdata[0], 32'd0);
    chk("rst_drdata", data_rdata[1], 32'd0);
    cycle();
    cycle();
    resetn = 1'b1;

    // Single fetch
    cycle(); inst_req = 1'b1; inst_addr = 32'h1C00_0000; #1;
    chk("f_iaok",  32'(inst_addr_ok[0]), 32'd1);
    chk("f_daok",  32'(data_addr_ok[0]), 32'd0);
    cycle(); inst_req = 1'b0; mem_gnt = 1'b1; #1;
    chk("f_mreq",  32'(mem_req[0]), 32'd1);
    chk("f_maddr", mem_addr[0], 32'h1C00_0000);
    chk("f_mwr",   32'(mem_wr[0]), 32'd0);
    cycle(); mem_gnt = 1'b0; #1;
    chk("f_mreq_drop", 32'(mem_req[0]), 32'd0);
    chk("f_busy_wait", 32'(busy[0]), 32'd1);
    cycle(); mem_rvalid = 1'b1; mem_rdata = 32'h0280_0C0C; #1;
    chk("f_dok_early", 32'(inst_data_ok[0]), 32'd0);
    cycle(); mem_rvalid = 1'b0; #1;
    chk("f_idok",   32'(inst_data_ok[0]), 32'd1);
    chk("f_irdata", inst_rdata[0], 32'h0280_0C0C);
    chk("f_busy",   32'(busy[0]), 32'd0);
    cycle(); #1;
    chk("f_idok_pulse", 32'(inst_data_ok[0]), 32'd0);

    // Simultaneous requests: data first, inst granted in the data_ok cycle
    inst_req = 1'b1; inst_addr = 32'h1C00_0004;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'hF; data_addr = 32'h0000_0100; #1;
    chk("s_daok", 32'(data_addr_ok[0]), 32'd1);
    chk("s_iaok", 32'(inst_addr_ok[0]), 32'd0);
    cycle(); data_req = 1'b0; mem_gnt = 1'b1; #1;
    chk("s_maddr",  mem_addr[0], 32'h0000_0100);
    chk("s_mwstrb", 32'(mem_wstrb[0]), 32'd0);
    chk("s_iaok_issue", 32'(inst_addr_ok[0]), 32'd0);
    cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1122_3344; #1;
    chk("s_iaok_wait", 32'(inst_addr_ok[0]), 32'd0);
    cycle(); mem_rvalid = 1'b0; #1;
    chk("s_ddok",   32'(data_data_ok[0]), 32'd1);
    chk("s_drdata", data_rdata[0], 32'h1122_3344);
    chk("s_iaok_b2b", 32'(inst_addr_ok[0]), 32'd1);
    cycle(); inst_req = 1'b0; mem_gnt = 1'b1; #1;
    chk("s_maddr2", mem_addr[0], 32'h1C00_0004);
    cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
    cycle(); mem_rvalid = 1'b0; #1;
    chk("s_idok",    32'(inst_data_ok[0]), 32'd1);
    chk("s_irdata",  inst_rdata[0], 32'hAAAA_5555);
    chk("s_drdata_hold", data_rdata[0], 32'h1122_3344);

    // Both channels requesting for four transactions
    cycle();
    inst_req = 1'b1; inst_addr = 32'h1C00_0100;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0300;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_daok",   32'(data_addr_ok[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_iaok",   32'(inst_addr_ok[1]), (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("prio_daok", 32'(data_addr_ok[0]), 32'd1);
      cycle(); mem_gnt = 1'b1; #1;
      chk("rr_maddr", mem_addr[1], (i % 2 == 0) ? 32'h0000_0300 : 32'h1C00_0100);
      cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'(i);
      cycle(); mem_rvalid = 1'b0;
      if (i == 3) begin
        inst_req = 1'b0;
        data_req = 1'b0;
      end
    end

    // Store
    cycle();
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'h3;
    data_addr = 32'h0000_0200; data_wdata = 32'hDEAD_BEEF; #1;
    chk("st_daok", 32'(data_addr_ok[0]), 32'd1);
    cycle(); data_req = 1'b0; data_wr = 1'b0; data_wdata = '0; data_wstrb = '0; mem_gnt = 1'b1; #1;
    chk("st_mwr",    32'(mem_wr[0]), 32'd1);
    chk("st_mwstrb", 32'(mem_wstrb[0]), 32'h3);
    chk("st_mwdata", mem_wdata[0], 32'hDEAD_BEEF);
    chk("st_maddr",  mem_addr[0], 32'h0000_0200);
    cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    cycle(); mem_rvalid = 1'b0; #1;
    chk("st_ddok",    32'(data_data_ok[0]), 32'd1);
    chk("st_drdata0", data_rdata[0], 32'd3);
    chk("st_drdata1", data_rdata[1], 32'd2);

    // Grant stall with a competing inst request
    cycle();
    inst_req = 1'b1; inst_addr = 32'h1C00_0200;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_0400; #1;
    chk("gs_daok", 32'(data_addr_ok[0]), 32'd1);
    cycle(); data_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("gs_mreq",  32'(mem_req[0]), 32'd1);
      chk("gs_maddr", mem_addr[0], 32'h0000_0400);
      chk("gs_mwr",   32'(mem_wr[0]), 32'd0);
      chk("gs_iaok",  32'(inst_addr_ok[0]), 32'd0);
      cycle();
    end
    mem_gnt = 1'b1;
    cycle(); mem_gnt = 1'b0; #1;
    chk("gs_wait", 32'(busy[0]), 32'd1);

    // Reset while waiting, then a stray response in IDLE
    resetn = 1'b0; #1;
    chk("rw_busy",  32'(busy[0]), 32'd0);
    chk("rw_iaok",  32'(inst_addr_ok[0]), 32'd0);
    chk("rw_maddr", mem_addr[0], 32'd0);
    chk("rw_drdata", data_rdata[0], 32'd0);
    cycle(); inst_req = 1'b0; resetn = 1'b1; #1;
    chk("rw_ddok", 32'(data_data_ok[0]), 32'd0);
    cycle(); mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    cycle(); mem_rvalid = 1'b0; #1;
    chk("sr_err",    32'(err[0]), 32'd1);
    chk("sr_err_rr", 32'(err[1]), 32'd1);
    chk("sr_ddok",   32'(data_data_ok[0]), 32'd0);
    chk("sr_idok",   32'(inst_data_ok[0]), 32'd0);
    chk("sr_drdata", data_rdata[0], 32'd0);
    chk("sr_busy",   32'(busy[0]), 32'd0);
    cycle(); #1;
    chk("sr_err_sticky", 32'(err[0]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
